// File: rtl/convolucion_ventana_pipeline.sv
// Pipelined NxN window convolution against a signed mask held in a double-buffered
// coefficient bank, with valid/ready streaming, shift normalisation and output clamp.
module convolucion_ventana_pipeline #(
    parameter int TAM_VENTANA           = 5,
    parameter int BITS_PIXEL            = 8,
    parameter int BITS_ELEMENTO_MASCARA = 10,
    parameter int BITS_DESPLAZAMIENTO   = 4
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           mascara_valid,
    input  logic [BITS_ELEMENTO_MASCARA-1:0]               mascara_dato,
    input  logic                                           mascara_reiniciar,
    output logic                                           mascara_lista,
    input  logic                                           ventana_valid,
    output logic                                           ventana_ready,
    input  logic [TAM_VENTANA*TAM_VENTANA*BITS_PIXEL-1:0]  ventana_pixeles,
    input  logic [BITS_DESPLAZAMIENTO-1:0]                 desplazamiento,
    input  logic                                           modo_absoluto,
    output logic                                           pixel_valid,
    input  logic                                           pixel_ready,
    output logic [BITS_PIXEL-1:0]                          pixel_salida,
    output logic                                           pixel_saturado
);
    // Handshake: a transfer happens on a rising edge where valid && ready; valid
    // holds its data until that edge, and ready may depend combinationally on
    // downstream ready (ventana_ready follows pixel_ready through the stall logic).
    localparam int NT        = TAM_VENTANA * TAM_VENTANA;
    localparam int BP        = BITS_PIXEL;
    localparam int BEM       = BITS_ELEMENTO_MASCARA;
    localparam int BPR       = BP + BEM + 1;
    localparam int BITS_SUMA = BP + BEM + 1 + $clog2(NT);
    localparam int BI        = $clog2(NT);
    localparam logic [BI-1:0] ULTIMO = BI'(NT - 1);

    logic signed [BEM-1:0]       r_sombra [NT];
    logic signed [BEM-1:0]       r_activa [NT];
    logic [BI-1:0]               r_idx;
    logic                        r_mascara_lista;

    logic signed [BPR-1:0]       r_prod [NT];
    logic [BITS_DESPLAZAMIENTO-1:0] r_desp1, r_desp2;
    logic                        r_abs1, r_abs2;
    logic                        r_v1, r_v2, r_v3;
    logic signed [BITS_SUMA-1:0] r_suma;
    logic [BP-1:0]               r_pixel;
    logic                        r_sat;

    logic                        w_avanza;
    logic                        w_acepta;
    logic signed [BPR-1:0]       w_prod [NT];
    logic signed [BITS_SUMA-1:0] w_suma;
    logic signed [BITS_SUMA-1:0] w_desp;
    logic signed [BITS_SUMA-1:0] w_mag;
    logic [BP-1:0]               w_pixel;
    logic                        w_sat;

    assign w_avanza       = !r_v3 || pixel_ready;
    assign ventana_ready  = r_mascara_lista && w_avanza;
    assign w_acepta       = ventana_valid && ventana_ready;
    assign mascara_lista  = r_mascara_lista;
    assign pixel_valid    = r_v3;
    assign pixel_salida   = r_pixel;
    assign pixel_saturado = r_sat;

    // The last coefficient bypasses the shadow so the whole bank swaps on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NT; k++) begin
                r_sombra[k] <= '0;
                r_activa[k] <= '0;
            end
            r_idx           <= '0;
            r_mascara_lista <= 1'b0;
        end else if (mascara_reiniciar) begin
            r_idx <= '0;
        end else if (mascara_valid) begin
            r_sombra[r_idx] <= mascara_dato;
            if (r_idx == ULTIMO) begin
                for (int k = 0; k < NT; k++) begin
                    r_activa[k] <= (k == NT - 1) ? mascara_dato : r_sombra[k];
                end
                r_idx           <= '0;
                r_mascara_lista <= 1'b1;
            end else begin
                r_idx <= r_idx + BI'(1);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NT; k++) begin
            w_prod[k] = BPR'($signed({1'b0, ventana_pixeles[k*BP +: BP]})) * BPR'(r_activa[k]);
        end
    end

    always_comb begin
        w_suma = '0;
        for (int k = 0; k < NT; k++) begin
            w_suma = w_suma + BITS_SUMA'(r_prod[k]);
        end
    end

    // Arithmetic shift floors toward -inf; the sum range keeps negation overflow-free.
    always_comb begin
        w_desp  = r_suma >>> r_desp2;
        w_mag   = (r_abs2 && w_desp[BITS_SUMA-1]) ? -w_desp : w_desp;
        w_pixel = w_mag[BP-1:0];
        w_sat   = 1'b0;
        if (w_mag[BITS_SUMA-1]) begin
            w_pixel = '0;
            w_sat   = 1'b1;
        end else if (|w_mag[BITS_SUMA-2:BP]) begin
            w_pixel = '1;
            w_sat   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NT; k++) begin
                r_prod[k] <= '0;
            end
            r_desp1 <= '0;
            r_desp2 <= '0;
            r_abs1  <= 1'b0;
            r_abs2  <= 1'b0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_suma  <= '0;
            r_pixel <= '0;
            r_sat   <= 1'b0;
        end else if (w_avanza) begin
            r_v1 <= w_acepta;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (w_acepta) begin
                for (int k = 0; k < NT; k++) begin
                    r_prod[k] <= w_prod[k];
                end
                r_desp1 <= desplazamiento;
                r_abs1  <= modo_absoluto;
            end
            if (r_v1) begin
                r_suma  <= w_suma;
                r_desp2 <= r_desp1;
                r_abs2  <= r_abs1;
            end
            if (r_v2) begin
                r_pixel <= w_pixel;
                r_sat   <= w_sat;
            end
        end
    end
endmodule

// File: tb/tb_convolucion_ventana_pipeline.sv
// Bench for convolucion_ventana_pipeline: directed cases plus random windows scored
// against an integer-arithmetic convolution model and an expected-result queue.
module tb_convolucion_ventana_pipeline;
    localparam int N   = 5;
    localparam int NT  = N * N;
    localparam int BP  = 8;
    localparam int BEM = 10;

    logic              clk;
    logic              rst_n;
    logic              mascara_valid;
    logic [BEM-1:0]    mascara_dato;
    logic              mascara_reiniciar;
    logic              mascara_lista;
    logic              ventana_valid;
    logic              ventana_ready;
    logic [NT*BP-1:0]  ventana_pixeles;
    logic [3:0]        desplazamiento;
    logic              modo_absoluto;
    logic              pixel_valid;
    logic              pixel_ready;
    logic [BP-1:0]     pixel_salida;
    logic              pixel_saturado;

    int          total = 0;
    int          bad = 0;
    int          out_count = 0;
    logic [8:0]  exp_q[$];
    int          m_act[NT];
    int          m_new[NT];
    logic        rand_ready = 1'b0;
    logic        held = 1'b0;
    logic [8:0]  held_v;
    logic [8:0]  got_e;

    convolucion_ventana_pipeline #(
        .TAM_VENTANA(N), .BITS_PIXEL(BP), .BITS_ELEMENTO_MASCARA(BEM), .BITS_DESPLAZAMIENTO(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mascara_valid(mascara_valid), .mascara_dato(mascara_dato),
        .mascara_reiniciar(mascara_reiniciar), .mascara_lista(mascara_lista),
        .ventana_valid(ventana_valid), .ventana_ready(ventana_ready),
        .ventana_pixeles(ventana_pixeles), .desplazamiento(desplazamiento),
        .modo_absoluto(modo_absoluto),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .pixel_salida(pixel_salida), .pixel_saturado(pixel_saturado)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout need completion");
        $fatal(1, "watchdog");
    end

    // Reference model: direct sum of products, floor division, magnitude, clamp.
    function automatic logic [8:0] model(input logic [NT*BP-1:0] pix, input int sh, input int ab);
        longint s, d, q;
        s = 0;
        for (int k = 0; k < NT; k++) s += longint'(pix[k*BP +: BP]) * longint'(m_act[k]);
        d = longint'(1) << sh;
        if (s >= 0) q = s / d;
        else q = -((-s + d - 1) / d);
        if (ab != 0 && q < 0) q = -q;
        if (q < 0) return {1'b1, 8'd0};
        if (q > 255) return {1'b1, 8'hff};
        return {1'b0, q[7:0]};
    endfunction

    function automatic logic [NT*BP-1:0] rand_win();
        logic [NT*BP-1:0] r;
        for (int k = 0; k < NT; k++) r[k*BP +: BP] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    function automatic logic [NT*BP-1:0] uni_win(input int v);
        logic [NT*BP-1:0] r;
        for (int k = 0; k < NT; k++) r[k*BP +: BP] = 8'(v);
        return r;
    endfunction

    // Scoreboard / output monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                total++;
                if (pixel_valid !== 1'b1 || {pixel_saturado, pixel_salida} !== held_v) begin
                    bad++;
                    $display("FAIL hold_stable: got v=%b {sat,pix}=%h need v=1 %h",
                             pixel_valid, {pixel_saturado, pixel_salida}, held_v);
                end
            end
            if (pixel_valid && pixel_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output: got %h need no result", {pixel_saturado, pixel_salida});
                end else begin
                    got_e = exp_q.pop_front();
                    if ({pixel_saturado, pixel_salida} !== got_e) begin
                        bad++;
                        $display("FAIL result: got sat=%b pix=%0d need sat=%b pix=%0d",
                                 pixel_saturado, pixel_salida, got_e[8], got_e[7:0]);
                    end
                end
                out_count++;
            end
            held   = pixel_valid && !pixel_ready;
            held_v = {pixel_saturado, pixel_salida};
        end
    end

    // Driver tasks (all start and end just after a rising edge)
    task automatic do_reset();
        rst_n = 1'b0;
        mascara_valid = 1'b0; mascara_dato = '0; mascara_reiniciar = 1'b0;
        ventana_valid = 1'b0; ventana_pixeles = '0; desplazamiento = '0; modo_absoluto = 1'b0;
        pixel_ready = 1'b1;
        for (int k = 0; k < NT; k++) m_act[k] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic load_mask();
        for (int k = 0; k < NT; k++) begin
            mascara_valid = 1'b1;
            mascara_dato  = 10'(m_new[k]);
            @(posedge clk); #1;
        end
        mascara_valid = 1'b0;
        for (int k = 0; k < NT; k++) m_act[k] = m_new[k];
    endtask

    task automatic send_win(input logic [NT*BP-1:0] pix, input int sh, input int ab, input logic [8:0] expv);
        int  tries;
        logic acc;
        tries = 0;
        acc   = 1'b0;
        ventana_valid   = 1'b1;
        ventana_pixeles = pix;
        desplazamiento  = 4'(sh);
        modo_absoluto   = (ab != 0);
        if (rand_ready) pixel_ready = 1'($urandom_range(0, 1));
        while (!acc && tries < 200) begin
            @(negedge clk);
            acc = ventana_ready;
            @(posedge clk); #1;
            tries++;
            if (rand_ready) pixel_ready = 1'($urandom_range(0, 1));
        end
        ventana_valid = 1'b0;
        if (acc) exp_q.push_back(expv);
        else begin
            total++; bad++;
            $display("FAIL accept_timeout: got no acceptance need ventana_ready within 200 cycles");
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        pixel_ready = 1'b1;
        while (exp_q.size() != 0 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d results outstanding need 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scenarios
    task automatic test_reset();
        total++; if (ventana_ready !== 1'b0)  begin bad++; $display("FAIL reset_ventana_ready: got %b need 0", ventana_ready); end
        total++; if (pixel_valid !== 1'b0)    begin bad++; $display("FAIL reset_pixel_valid: got %b need 0", pixel_valid); end
        total++; if (pixel_salida !== 8'd0)   begin bad++; $display("FAIL reset_pixel_salida: got %0d need 0", pixel_salida); end
        total++; if (pixel_saturado !== 1'b0) begin bad++; $display("FAIL reset_saturado: got %b need 0", pixel_saturado); end
        total++; if (mascara_lista !== 1'b0)  begin bad++; $display("FAIL reset_mascara_lista: got %b need 0", mascara_lista); end
    endtask

    task automatic test_centre();
        logic [NT*BP-1:0] w;
        int lat;
        for (int k = 0; k < NT; k++) m_new[k] = 0;
        m_new[12] = 1;
        load_mask();
        total++; if (mascara_lista !== 1'b1) begin bad++; $display("FAIL load_lista: got %b need 1", mascara_lista); end
        w = rand_win();
        w[12*BP +: BP] = 8'd200;
        send_win(w, 0, 0, {1'b0, 8'd200});
        lat = 0;
        for (int n = 1; n <= 5 && lat == 0; n++) begin
            @(negedge clk);
            if (pixel_valid) lat = n;
            @(posedge clk); #1;
        end
        total++; if (lat != 3) begin bad++; $display("FAIL latency: got %0d cycles need 3", lat); end
        drain();
    endtask

    task automatic test_ones();
        for (int k = 0; k < NT; k++) m_new[k] = 1;
        load_mask();
        send_win(uni_win(255), 5, 0, {1'b0, 8'd199});
        drain();
    endtask

    task automatic test_negative();
        logic [NT*BP-1:0] w;
        for (int k = 0; k < NT; k++) m_new[k] = 0;
        m_new[12] = -1;
        load_mask();
        w = rand_win();
        w[12*BP +: BP] = 8'd100;
        send_win(w, 0, 0, {1'b1, 8'd0});
        send_win(w, 0, 1, {1'b0, 8'd100});
        drain();
    endtask

    task automatic test_extremes();
        logic [NT*BP-1:0] w;
        for (int k = 0; k < NT; k++) m_new[k] = 511;
        load_mask();
        send_win(uni_win(255), 0, 0, {1'b1, 8'hff});
        for (int k = 0; k < NT; k++) m_new[k] = -512;
        load_mask();
        send_win(uni_win(255), 15, 1, {1'b0, 8'd100});
        w = rand_win();
        send_win(w, 14, 1, model(w, 14, 1));
        drain();
    endtask

    task automatic test_random();
        logic [NT*BP-1:0] w;
        int sh, ab;
        for (int k = 0; k < NT; k++) m_new[k] = $urandom_range(0, 16) - 8;
        load_mask();
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 20) begin
                for (int k = 0; k < NT; k++) m_new[k] = $urandom_range(0, 1023) - 512;
                load_mask();
            end
            w  = rand_win();
            sh = (i < 20) ? $urandom_range(0, 7) : $urandom_range(8, 15);
            ab = $urandom_range(0, 1);
            send_win(w, sh, ab, model(w, sh, ab));
        end
        rand_ready = 1'b0;
        drain();
    endtask

    task automatic test_stall();
        logic [NT*BP-1:0] w;
        int sh, t;
        for (int k = 0; k < NT; k++) m_new[k] = 1;
        load_mask();
        pixel_ready = 1'b1;
        out_count = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    w  = rand_win();
                    sh = $urandom_range(3, 6);
                    send_win(w, sh, 0, model(w, sh, 0));
                end
            end
            begin
                t = 0;
                while (out_count < 1 && t < 100) begin
                    @(posedge clk); #1;
                    t++;
                end
                pixel_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    total++;
                    if (pixel_valid !== 1'b1 || ventana_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL stall_ready: got valid=%b ventana_ready=%b need valid=1 ventana_ready=0",
                                 pixel_valid, ventana_ready);
                    end
                    @(posedge clk); #1;
                end
                pixel_ready = 1'b1;
            end
        join
        drain();
        total++; if (out_count != 6) begin bad++; $display("FAIL stall_count: got %0d results need 6", out_count); end
    endtask

    task automatic test_reload();
        logic [NT*BP-1:0] w;
        logic [8:0] e;
        logic rdy;
        int ab;
        pixel_ready = 1'b1;
        for (int k = 0; k < NT; k++) m_new[k] = $urandom_range(0, 8) - 4;
        for (int k = 0; k < NT; k++) begin
            mascara_valid = 1'b1;
            mascara_dato  = 10'(m_new[k]);
            w  = rand_win();
            ab = $urandom_range(0, 1);
            ventana_valid = 1'b1; ventana_pixeles = w; desplazamiento = 4'd5; modo_absoluto = (ab != 0);
            e = model(w, 5, ab);
            @(negedge clk);
            rdy = ventana_ready;
            total++;
            if (rdy !== 1'b1) begin bad++; $display("FAIL load_no_stall: got ventana_ready=%b need 1 at coef %0d", rdy, k); end
            @(posedge clk); #1;
            if (rdy) exp_q.push_back(e);
        end
        mascara_valid = 1'b0;
        ventana_valid = 1'b0;
        for (int k = 0; k < NT; k++) m_act[k] = m_new[k];
        w = rand_win();
        send_win(w, 5, 1, model(w, 5, 1));
        drain();
        // partial load then abort; reiniciar on the 8th coefficient drops it
        for (int k = 0; k < 8; k++) begin
            mascara_valid = 1'b1;
            mascara_dato  = 10'd7;
            mascara_reiniciar = (k == 7);
            @(posedge clk); #1;
        end
        mascara_valid = 1'b0;
        mascara_reiniciar = 1'b0;
        total++; if (mascara_lista !== 1'b1) begin bad++; $display("FAIL abort_lista: got %b need 1", mascara_lista); end
        for (int i = 0; i < 3; i++) begin
            w = rand_win();
            send_win(w, 4, 0, model(w, 4, 0));
        end
        for (int k = 0; k < NT; k++) m_new[k] = $urandom_range(0, 6) - 3;
        m_new[0] = 9;
        load_mask();
        for (int i = 0; i < 3; i++) begin
            w = rand_win();
            send_win(w, 2, 1, model(w, 2, 1));
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic [NT*BP-1:0] w;
        pixel_ready = 1'b0;
        w = rand_win();
        send_win(w, 3, 0, model(w, 3, 0));
        send_win(w, 3, 1, model(w, 3, 1));
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++; if (pixel_valid !== 1'b0)   begin bad++; $display("FAIL rst_mid_valid: got %b need 0", pixel_valid); end
        total++; if (mascara_lista !== 1'b0) begin bad++; $display("FAIL rst_mid_lista: got %b need 0", mascara_lista); end
        total++; if (pixel_salida !== 8'd0)  begin bad++; $display("FAIL rst_mid_pixel: got %0d need 0", pixel_salida); end
        exp_q.delete();
        for (int k = 0; k < NT; k++) m_act[k] = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pixel_ready = 1'b1;
        ventana_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (ventana_ready !== 1'b0 || pixel_valid !== 1'b0) begin
                bad++;
                $display("FAIL no_mask_accept: got ventana_ready=%b pixel_valid=%b need 0 0", ventana_ready, pixel_valid);
            end
            @(posedge clk); #1;
        end
        ventana_valid = 1'b0;
        for (int k = 0; k < NT; k++) m_new[k] = 0;
        m_new[24] = 2;
        load_mask();
        w = rand_win();
        send_win(w, 1, 0, model(w, 1, 0));
        drain();
    endtask

    initial begin
        do_reset();
        test_reset();
        test_centre();
        test_ones();
        test_negative();
        test_extremes();
        test_random();
        test_stall();
        test_reload();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
